dp_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit datapath.
- Fetches 16-bit instructions over a req/valid handshake and presents the 8-bit immediate to the registered sign-extend stage.
- Waits one cycle for that stage's latency, then drives ALU, register-file and PC control.
- Sits between the instruction source and the datapath; it does not compute data itself.

---
 rtl/dp_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dp_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: multi-cycle sequencer for the 16-bit datapath.
// Fetches an instruction over a req/valid handshake, dwells one cycle in
// DECODE for the registered sign-extend stage, then drives ALU, register
// file and PC control for one EXEC cycle.
// Optional build macro: ILLEGAL_TRAP_EN -- an illegal opcode halts the
// sequencer at the offending address instead of executing as a NOP.
module dp_seq_ctrl #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic              zero_in,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc,
    output logic [7:0]        imm_out,
    output logic [REG_AW-1:0] rd_addr,
    output logic [REG_AW-1:0] rs_addr,
    output logic [1:0]        alu_op,
    output logic              alu_src_imm,
    output logic              reg_we,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_LI   = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   ir_nxt;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_nxt;
    logic                illegal_q;
    logic                illegal_nxt;
    logic [3:0]          opcode;
    logic                writes_rd;

    // Sign-extend the 8-bit branch offset to PC width; truncation gives
    // modulo-2^PC_W arithmetic when added to the pc.
    function automatic logic [PC_W-1:0] sext_off(input logic [7:0] v);
        logic signed [PC_W+7:0] w;
        w = {{PC_W{v[7]}}, v};
        return w[PC_W-1:0];
    endfunction

    assign opcode = ir[15:12];

    // Field decode from ir; held between instructions since ir only changes
    // when a new instruction is accepted.
    always_comb begin
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        writes_rd   = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_op = 2'b01; alu_src_imm = 1'b0; writes_rd = 1'b1; end
            OP_SUB:  begin alu_op = 2'b10; alu_src_imm = 1'b0; writes_rd = 1'b1; end
            OP_ADDI: begin alu_op = 2'b01; alu_src_imm = 1'b1; writes_rd = 1'b1; end
            OP_LI:   begin alu_op = 2'b00; alu_src_imm = 1'b1; writes_rd = 1'b1; end
            default: begin alu_op = 2'b00; alu_src_imm = 1'b0; writes_rd = 1'b0; end
        endcase
    end

    // Next-state, next-pc, instruction latch and sticky illegal flag.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        ir_nxt      = ir;
        illegal_nxt = illegal_q;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (instr_valid) begin
                    ir_nxt    = instr;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // One-cycle dwell while the sign-extend register settles.
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LI: begin
                        pc_nxt = pc_q + PC_W'(1);
                    end
                    OP_BEQZ: begin
                        // Offset is relative to the branch's own address.
                        pc_nxt = zero_in ? (pc_q + sext_off(ir[7:0])) : (pc_q + PC_W'(1));
                    end
                    OP_HALT: begin
                        state_nxt = S_HALTED;
                    end
                    default: begin
                        illegal_nxt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        state_nxt = S_HALTED;
`else
                        pc_nxt = pc_q + PC_W'(1);
`endif
                    end
                endcase
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pc, instruction register and illegal flag with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc_q      <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc_q      <= pc_nxt;
            ir        <= ir_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    assign pc        = pc_q;
    assign imm_out   = ir[7:0];
    assign rd_addr   = ir[8 +: REG_AW];
    assign rs_addr   = ir[4 +: REG_AW];
    assign instr_req = (state == S_FETCH);
    assign reg_we    = (state == S_EXEC) && writes_rd;
    assign busy      = (state != S_IDLE) && (state != S_HALTED);
    assign halted    = (state == S_HALTED);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Directed testbench for dp_seq_ctrl (honours ILLEGAL_TRAP_EN if defined).
module tb_dp_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic        instr_valid;
    logic        zero_in;
    logic        instr_req;
    logic [7:0]  pc;
    logic [7:0]  imm_out;
    logic [3:0]  rd_addr;
    logic [3:0]  rs_addr;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_we;
    logic        busy;
    logic        halted;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    int         req_cnt;
    int         we_cnt;
    logic [1:0] s_op;
    logic       s_src;
    logic [3:0] s_rd;
    logic [7:0] s_imm;

    dp_seq_ctrl #(.PC_W(8), .DATA_W(16), .REG_AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero_in     (zero_in),
        .instr_req   (instr_req),
        .pc          (pc),
        .imm_out     (imm_out),
        .rd_addr     (rd_addr),
        .rs_addr     (rs_addr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter at #1 after an edge with the DUT in FETCH; leave after EXEC.
    task automatic run_instr(input logic [15:0] w, input logic z, input int wait_n,
                             output int rq, output int we, output logic [1:0] op,
                             output logic src, output logic [3:0] rd, output logic [7:0] imm);
        rq = 0;
        we = 0;
        zero_in = z;
        for (int i = 0; i < wait_n; i++) begin
            instr = 16'h4A55;
            instr_valid = 1'b0;
            if (instr_req) rq++;
            if (reg_we) we++;
            step();
        end
        instr = w;
        instr_valid = 1'b1;
        if (instr_req) rq++;
        if (reg_we) we++;
        step();
        if (instr_req) rq++;
        if (reg_we) we++;
        step();
        op  = alu_op;
        src = alu_src_imm;
        rd  = rd_addr;
        imm = imm_out;
        if (instr_req) rq++;
        if (reg_we) we++;
        step();
        if (reg_we) we++;
    endtask

    task automatic reset_and_start();
        reset = 1'b1;
        start = 1'b0;
        instr_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = 16'h0000;
        instr_valid = 1'b0;
        zero_in = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_req", instr_req, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_fields", {imm_out, rd_addr, alu_op, alu_src_imm}, 0);

        // LI r1,0xFE ; HALT
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_req", instr_req, 1);
        chk("start_busy", busy, 1);
        run_instr(16'h41FE, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("li_we_cnt", we_cnt, 1);
        chk("li_rd", s_rd, 1);
        chk("li_op", s_op, 2'b00);
        chk("li_src", s_src, 1);
        chk("li_imm", s_imm, 8'hFE);
        chk("li_pc", pc, 1);
        run_instr(16'hF000, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc", pc, 1);
        chk("halt_req", instr_req, 0);
        chk("halt_we", we_cnt, 0);

        // Delayed instr_valid, ADD r3,r4 after a 5-cycle wait
        reset_and_start();
        run_instr(16'h1340, 1'b0, 5, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("wait_req_cnt", req_cnt, 6);
        chk("wait_we_cnt", we_cnt, 1);
        chk("wait_rd", s_rd, 3);
        chk("wait_op", {s_op, s_src}, 3'b010);
        chk("wait_rs", rs_addr, 4);
        chk("wait_pc", pc, 1);

        // Branches and wrap
        reset_and_start();
        run_instr(16'h5210, 1'b1, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_to_10", pc, 8'h10);
        chk("br_we", we_cnt, 0);
        run_instr(16'h52F8, 1'b1, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_back_taken", pc, 8'h08);
        run_instr(16'h5208, 1'b1, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_fwd_taken", pc, 8'h10);
        run_instr(16'h52F8, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_not_taken", pc, 8'h11);
        run_instr(16'h52EE, 1'b1, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_to_ff", pc, 8'hFF);
        run_instr(16'h0000, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("nop_wrap", pc, 8'h00);
        chk("nop_we", we_cnt, 0);
        run_instr(16'h0000, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        run_instr(16'h0000, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("nop_pc2", pc, 8'h02);
        run_instr(16'h52FC, 1'b1, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("br_wrap_back", pc, 8'hFE);

        // Illegal opcode 0x7
        chk("pre_illegal", illegal, 0);
        run_instr(16'h7123, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("ill_flag", illegal, 1);
        chk("ill_we", we_cnt, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap_halted", halted, 1);
        chk("ill_trap_pc", pc, 8'hFE);
`else
        chk("ill_halted", halted, 0);
        chk("ill_pc", pc, 8'hFF);
        run_instr(16'h3503, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("addi_we", we_cnt, 1);
        chk("addi_ctl", {s_op, s_src, s_rd, s_imm}, {2'b01, 1'b1, 4'h5, 8'h03});
        chk("addi_pc_wrap", pc, 8'h00);
        chk("ill_sticky", illegal, 1);
`endif

        // Reset during DECODE of ADD, with instr_valid still high
        reset_and_start();
        chk("rst_clears_ill", illegal, 0);
        instr = 16'h1120;
        instr_valid = 1'b1;
        step();
        chk("dec_busy", busy, 1);
        chk("dec_we", reg_we, 0);
        reset = 1'b1;
        step();
        chk("dec_rst_state", {busy, halted, instr_req, reg_we}, 4'b0000);
        chk("dec_rst_pc", pc, 0);
        chk("dec_rst_rd", rd_addr, 0);
        reset = 1'b0;
        step();
        chk("dec_rst_idle", {busy, reg_we, instr_req}, 3'b000);

        // Reset mid-fetch drops instr_req
        start = 1'b1;
        step();
        start = 1'b0;
        instr_valid = 1'b0;
        chk("mf_req", instr_req, 1);
        reset = 1'b1;
        step();
        chk("mf_req_drop", instr_req, 0);
        reset = 1'b0;

        // Start held high while busy and halted has no effect
        start = 1'b1;
        step();
        step();
        chk("sb_fetch", {instr_req, pc}, {1'b1, 8'h00});
        run_instr(16'h4201, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        chk("sb_li_pc", pc, 1);
        chk("sb_li_we", we_cnt, 1);
        run_instr(16'hF000, 1'b0, 0, req_cnt, we_cnt, s_op, s_src, s_rd, s_imm);
        step();
        step();
        chk("sb_halted", {halted, busy, instr_req, pc}, {1'b1, 1'b0, 1'b0, 8'h01});
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
